// File: rtl/e_stream.sv
// e_stream: two-stage valid/ready unary/thermometer classifier with saturating admit/reject counters.
// Latency 2, one word/cycle; E_STREAM_DROP_INVALID_EN drops rejected words at S2 entry.
module e_stream #(
  parameter int W                     = 16,
  parameter int P_ADMIT_COMPLIMENT_EN = 1,
  parameter int P_CNT_W               = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  input  logic [W-1:0]         i_x,
  output logic                 o_ready,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [W-1:0]         o_x,
  output logic                 o_is_unary,
  output logic                 o_is_compliment,
  output logic [$clog2(W)-1:0] o_count,
  input  logic                 i_clr_cnt,
  output logic [P_CNT_W-1:0]   o_admit_cnt,
  output logic [P_CNT_W-1:0]   o_reject_cnt
);
  localparam int CW = $clog2(W);
`ifdef E_STREAM_DROP_INVALID_EN
  localparam bit DropRej = 1'b1;
`else
  localparam bit DropRej = 1'b0;
`endif
  localparam bit CmpEn = (P_ADMIT_COMPLIMENT_EN != 0);
  localparam logic [P_CNT_W-1:0] CntOne = 1;

  logic           s1_vld_q;
  logic [W-1:0]   s1_x_q;
  logic [W-1:0]   s1_edg_q;
  logic [W-1:0]   edg_d;
  logic           s2_vld_q;
  logic [W-1:0]   s2_x_q;
  logic           s2_unary_q;
  logic           s2_cmp_q;
  logic [CW-1:0]  s2_cnt_q;
  logic [P_CNT_W-1:0] adm_q, adm_d;
  logic [P_CNT_W-1:0] rej_q, rej_d;

  logic          in_xfer, out_xfer, s1_adv, s2_ld;
  logic [CW:0]   ones, zeros;
  logic          one_edge, std_form, cmp_form, cls_unary;
  logic [CW-1:0] cls_count;
  logic          adm_inc, rej_inc;

  assign in_xfer  = i_valid & o_ready;
  assign s1_adv   = s1_vld_q & (~s2_vld_q | i_ready);
  assign o_ready  = ~rst & (~s1_vld_q | s1_adv);
  assign out_xfer = s2_vld_q & i_ready;

  assign edg_d = {i_x[W-1:1] ^ i_x[W-2:0], 1'b0};

  always_comb begin
    ones = '0;
    for (int i = 0; i < W; i++) ones = ones + (CW+1)'(s1_x_q[i]);
  end
  assign zeros = (CW+1)'(W) - ones;

  // A single transition means two runs; which end holds the ones picks the form.
  assign one_edge  = $onehot(s1_edg_q);
  assign std_form  = ~|s1_x_q | (one_edge & s1_x_q[0]);
  assign cmp_form  = CmpEn & (&s1_x_q | (one_edge & s1_x_q[W-1]));
  assign cls_unary = std_form | cmp_form;
  assign cls_count = cmp_form ? CW'(zeros) : (std_form ? CW'(ones) : '0);

  assign s2_ld   = s1_adv & (cls_unary | ~DropRej);
  assign adm_inc = out_xfer & s2_unary_q;
  assign rej_inc = DropRej ? (s1_adv & ~cls_unary) : (out_xfer & ~s2_unary_q);

  always_comb begin
    adm_d = adm_q;
    rej_d = rej_q;
    if (i_clr_cnt) begin
      adm_d = '0;
      rej_d = '0;
    end else begin
      if (adm_inc && (adm_q != '1)) adm_d = adm_q + CntOne;
      if (rej_inc && (rej_q != '1)) rej_d = rej_q + CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q   <= 1'b0;
      s1_x_q     <= '0;
      s1_edg_q   <= '0;
      s2_vld_q   <= 1'b0;
      s2_x_q     <= '0;
      s2_unary_q <= 1'b0;
      s2_cmp_q   <= 1'b0;
      s2_cnt_q   <= '0;
      adm_q      <= '0;
      rej_q      <= '0;
    end else begin
      if (in_xfer) begin
        s1_vld_q <= 1'b1;
        s1_x_q   <= i_x;
        s1_edg_q <= edg_d;
      end else if (s1_adv) begin
        s1_vld_q <= 1'b0;
      end
      if (s2_ld) begin
        s2_vld_q   <= 1'b1;
        s2_x_q     <= s1_x_q;
        s2_unary_q <= cls_unary;
        s2_cmp_q   <= cmp_form;
        s2_cnt_q   <= cls_count;
      end else if (out_xfer) begin
        s2_vld_q <= 1'b0;
      end
      adm_q <= adm_d;
      rej_q <= rej_d;
    end
  end

  assign o_valid         = s2_vld_q;
  assign o_x             = s2_x_q;
  assign o_is_unary      = s2_unary_q;
  assign o_is_compliment = s2_cmp_q;
  assign o_count         = s2_cnt_q;
  assign o_admit_cnt     = adm_q;
  assign o_reject_cnt    = rej_q;
endmodule

// File: tb/tb_e_stream.sv
// Scoreboard bench for e_stream: main DUT (compliment on, 4-bit counters) and a compliment-off DUT.
module tb_e_stream;
`ifdef E_STREAM_DROP_INVALID_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif
  localparam logic [15:0] BURST [5] = '{16'h0000, 16'h0007, 16'hFFF8, 16'hFFFF, 16'h0005};
  localparam logic [15:0] BPW   [3] = '{16'h00FF, 16'hFF00, 16'h0001};

  typedef struct {
    logic [15:0] x;
    bit          u;
    bit          c;
    logic [3:0]  cnt;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic v1 = 1'b0, v2 = 1'b0, i_ready = 1'b1, i_clr = 1'b0;
  logic [15:0] x1 = '0, x2 = '0;
  logic o_ready1, o_valid1, o_u1, o_c1, o_ready2, o_valid2, o_u2, o_c2;
  logic [15:0] o_x1, o_x2;
  logic [3:0]  o_cnt1, o_adm1, o_rej1, o_cnt2, o_adm2, o_rej2;

  e_stream #(.W(16), .P_ADMIT_COMPLIMENT_EN(1), .P_CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .i_valid(v1), .i_x(x1), .o_ready(o_ready1),
    .o_valid(o_valid1), .i_ready(i_ready), .o_x(o_x1), .o_is_unary(o_u1),
    .o_is_compliment(o_c1), .o_count(o_cnt1), .i_clr_cnt(i_clr),
    .o_admit_cnt(o_adm1), .o_reject_cnt(o_rej1));

  e_stream #(.W(16), .P_ADMIT_COMPLIMENT_EN(0), .P_CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .i_valid(v2), .i_x(x2), .o_ready(o_ready2),
    .o_valid(o_valid2), .i_ready(i_ready), .o_x(o_x2), .o_is_unary(o_u2),
    .o_is_compliment(o_c2), .o_count(o_cnt2), .i_clr_cnt(i_clr),
    .o_admit_cnt(o_adm2), .o_reject_cnt(o_rej2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t q1[$];
  exp_t q2[$];
  int n_vec = 0, n_miss = 0;
  int adm_m = 0, rej_m = 0;
  bit rdy_rand = 1'b0, chk_lat = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // Reference: a word is admitted iff it equals (1<<k)-1, or with compliment on ~((1<<k)-1), k in 0..15.
  function automatic exp_t model(input logic [15:0] x, input bit en);
    exp_t e;
    logic [15:0] t;
    e.x = x; e.u = 1'b0; e.c = 1'b0; e.cnt = '0; e.acc = 0;
    for (int k = 0; k < 16; k++) begin
      t = 16'((32'd1 << k) - 32'd1);
      if (x == t) begin
        e.u = 1'b1; e.cnt = 4'(k);
      end else if (en && x == ~t) begin
        e.u = 1'b1; e.c = 1'b1; e.cnt = 4'(k);
      end
    end
    return e;
  endfunction

  function automatic int sat(input int v);
    return (v < 15) ? v + 1 : 15;
  endfunction

  task automatic push(input bit sel, input logic [15:0] w);
    exp_t e;
    e = model(w, !sel);
    e.acc = cyc;
    if (sel) begin
      if (e.u || !DROP) q2.push_back(e);
    end else begin
      if (e.u || !DROP) q1.push_back(e);
      if (DROP && !e.u) rej_m = sat(rej_m);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_rand) i_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input bit sel, input logic [15:0] w);
    int n;
    n = 0;
    if (sel) begin v2 = 1'b1; x2 = w; end
    else begin v1 = 1'b1; x1 = w; end
    forever begin
      @(negedge clk);
      if (sel ? o_ready2 : o_ready1) begin
        push(sel, w);
        break;
      end
      n++;
      if (n > 100) begin
        timeout("accept");
        break;
      end
      tick();
    end
    tick();
    v1 = 1'b0;
    v2 = 1'b0;
  endtask

  task automatic idle(input int n);
    v1 = 1'b0;
    repeat (n) tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    rdy_rand = 1'b0;
    i_ready = 1'b1;
    while ((q1.size() != 0 || q2.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) timeout("drain");
    tick();
    tick();
  endtask

  initial begin : mon1
    bit pv_stall;
    logic [15:0] px;
    logic [5:0] pflags;
    exp_t e;
    pv_stall = 1'b0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (pv_stall) begin
        chk("stall_valid", o_valid1, 1);
        chk("stall_x", o_x1, px);
        chk("stall_flags", {o_u1, o_c1, o_cnt1}, pflags);
      end
      if (!DROP) begin
        chk("admit_cnt", o_adm1, adm_m);
        chk("reject_cnt", o_rej1, rej_m);
      end
      if (rst) begin
        adm_m = 0;
        rej_m = 0;
        pv_stall = 1'b0;
      end else begin
        if (o_valid1 && i_ready) begin
          if (q1.size() == 0) begin
            timeout("unexpected_output");
          end else begin
            e = q1.pop_front();
            chk("out_x", o_x1, e.x);
            chk("out_unary", o_u1, e.u);
            chk("out_cmp", o_c1, e.c);
            chk("out_count", o_cnt1, e.cnt);
            if (chk_lat) chk("latency", cyc - e.acc, 2);
            if (!i_clr) begin
              if (e.u) adm_m = sat(adm_m);
              else if (!DROP) rej_m = sat(rej_m);
            end
          end
        end
        if (i_clr) begin
          adm_m = 0;
          rej_m = 0;
        end
        pv_stall = o_valid1 && !i_ready;
        px = o_x1;
        pflags = {o_u1, o_c1, o_cnt1};
      end
    end
  end

  initial begin : mon2
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (!rst && o_valid2 && i_ready) begin
        if (q2.size() == 0) begin
          timeout("unexpected_output2");
        end else begin
          e = q2.pop_front();
          chk("en0_x", o_x2, e.x);
          chk("en0_unary", o_u2, e.u);
          chk("en0_cmp", o_c2, e.c);
          chk("en0_count", o_cnt2, e.cnt);
        end
      end
    end
  end

  initial begin : drive
    int acc, k, n;
    logic rdy_last;
    logic [15:0] w;

    rst = 1'b1;
    i_ready = 1'b1;
    repeat (3) tick();
    chk("rst_ready", o_ready1, 0);
    chk("rst_valid", o_valid1, 0);
    chk("rst_admit", o_adm1, 0);
    chk("rst_reject", o_rej1, 0);
    chk("rst_x", o_x1, 0);
    chk("rst_flags", {o_u1, o_c1, o_cnt1}, 0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", o_ready1, 1);

    chk_lat = 1'b1;
    for (int i = 0; i < 5; i++) send(1'b0, BURST[i]);
    drain();
    chk_lat = 1'b0;
    chk("burst_admit", o_adm1, 4);
    chk("burst_reject", o_rej1, 1);

    send(1'b1, 16'hFFFF);
    send(1'b1, 16'h8000);
    send(1'b1, 16'h7FFF);
    drain();
    chk("en0_admit_cnt", o_adm2, 1);
    chk("en0_reject_cnt", o_rej2, 2);

    i_ready = 1'b0;
    acc = 0;
    rdy_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      v1 = 1'b1;
      x1 = BPW[acc];
      @(negedge clk);
      rdy_last = o_ready1;
      if (o_ready1) begin
        push(1'b0, x1);
        acc++;
      end
      tick();
    end
    v1 = 1'b0;
    chk("bp_accepts", acc, 2);
    chk("bp_ready_low", rdy_last, 0);
    drain();

    rdy_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (i == 150) begin
        v1 = 1'b0;
        rst = 1'b1;
        q1.delete();
        tick();
        tick();
        chk("midrst_valid", o_valid1, 0);
        chk("midrst_admit", o_adm1, 0);
        rst = 1'b0;
      end
      k = $urandom_range(0, 15);
      case ($urandom_range(0, 3))
        0: w = 16'((32'd1 << k) - 32'd1);
        1: w = ~16'((32'd1 << k) - 32'd1);
        default: w = 16'($urandom);
      endcase
      send(1'b0, w);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain();
    chk("rand_admit", o_adm1, adm_m);
    chk("rand_reject", o_rej1, rej_m);

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) send(1'b0, 16'((32'd1 << (i % 16)) - 32'd1));
    drain();
    chk("sat_admit", o_adm1, 15);
    chk("sat_reject", o_rej1, 0);

    i_ready = 1'b0;
    send(1'b0, 16'h0003);
    n = 0;
    while (!o_valid1 && n < 10) begin
      tick();
      n++;
    end
    if (!o_valid1) timeout("clr_wait");
    i_ready = 1'b1;
    i_clr = 1'b1;
    tick();
    i_clr = 1'b0;
    chk("clr_admit", o_adm1, 0);
    chk("clr_reject", o_rej1, 0);
    chk("clr_drained", o_valid1, 0);

    send(1'b0, 16'h0003);
    send(1'b0, 16'h0A00);
    send(1'b0, 16'h000F);
    drain();
    chk("mix_admit", o_adm1, 2);
    chk("mix_reject", o_rej1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog expired");
  end
endmodule
